// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - result-producer and CDB signal bundle for cdb_arbiter
//
// Ports grouped here:
//   flush      : synchronous pipeline flush
//   src_valid  : per-source result valid            [NUM_SRC]
//   src_tag    : per-source target tag, source i at [i*TAG_W +: TAG_W]
//   src_data   : per-source result, source i at     [i*DATA_W +: DATA_W]
//   src_ready  : per-source holding FIFO not full   [NUM_SRC]
//   cdb_valid  : CDB carries a result
//   cdb_tag    : broadcast target tag
//   cdb_data   : broadcast result
//   cdb_src    : index of the granted source
//   rob_ready  : ROB accepts the CDB word this cycle
// master = producers/ROB side, slave = arbiter side.

interface cdb_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic                      flush;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ready;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic [SRC_W-1:0]          cdb_src;
    logic                      rob_ready;

    modport master (
        output flush, src_valid, src_tag, src_data, rob_ready,
        input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  flush, src_valid, src_tag, src_data, rob_ready,
        output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing the common data bus among result producers
//
// Each source pushes (tag, result) pairs into a private circular FIFO. One FIFO
// head per cycle is granted round-robin and loaded into the registered CDB
// output toward the ROB. The ROB can stall the bus; flush drops everything.
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : cdb_arbiter_if.slave (flush, src_valid/tag/data, src_ready,
//         cdb_valid/tag/data/src, rob_ready)

module cdb_arbiter #(
    parameter int               NUM_SRC     = 4,
    parameter int               TAG_W       = 5,
    parameter int               DATA_W      = 32,
    parameter int               FIFO_DEPTH  = 2,
    parameter logic [TAG_W-1:0] TAG_INVALID = '1
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // (p + k) mod NUM_SRC for k < NUM_SRC; a single subtraction suffices.
    function automatic logic [SRC_W-1:0] src_inc(input logic [SRC_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_SRC) s = s - NUM_SRC;
        return SRC_W'(s);
    endfunction

    // FIFO storage and bookkeeping
    logic [TAG_W-1:0]  mem_tag_q  [NUM_SRC][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_q [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_SRC];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_SRC];
    logic [CNT_W-1:0]  count_q  [NUM_SRC];
    logic [CNT_W-1:0]  count_d  [NUM_SRC];

    // Arbitration and output register
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

    logic [NUM_SRC-1:0] src_ready;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               out_free;
    logic               grant_found;
    logic [SRC_W-1:0]   grant;
    logic [SRC_W-1:0]   cand;

    // Ready comes from registered count only: a full FIFO stays not-ready even
    // in a cycle where it is popped, so ready never depends on rob_ready.
    always_comb begin
        src_ready = '0;
        push      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = count_q[i] < CNT_W'(FIFO_DEPTH);
            push[i]      = bus.src_valid[i] && src_ready[i] && !bus.flush &&
                           (bus.src_tag[i*TAG_W +: TAG_W] != TAG_INVALID);
        end
    end

    // Output register can take a new word when empty or when the ROB is
    // taking the current one this cycle.
    assign out_free = !cdb_valid_q || bus.rob_ready;

    // Scan from rr_ptr upward and take the first non-empty FIFO.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        cand        = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = src_inc(rr_ptr_q, k);
            if (!grant_found && (count_q[cand] != '0)) begin
                grant_found = 1'b1;
                grant       = cand;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i] = out_free && grant_found && !bus.flush && (grant == SRC_W'(i));
        end
    end

    // FIFO pointer/count next state; pointers wrap naturally (power-of-two depth).
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            rd_ptr_d[i] = rd_ptr_q[i];
            wr_ptr_d[i] = wr_ptr_q[i];
            count_d[i]  = count_q[i];
            if (bus.flush) begin
                rd_ptr_d[i] = '0;
                wr_ptr_d[i] = '0;
                count_d[i]  = '0;
            end else begin
                if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
                if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
                case ({push[i], pop[i]})
                    2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                    2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                    default: count_d[i] = count_q[i];
                endcase
            end
        end
    end

    // Output register and round-robin pointer next state. When stalled
    // (valid && !rob_ready) nothing changes; data/src hold when the bus idles.
    always_comb begin
        cdb_valid_d = cdb_valid_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (bus.flush) begin
            cdb_valid_d = 1'b0;
            cdb_tag_d   = TAG_INVALID;
            rr_ptr_d    = '0;
        end else if (out_free) begin
            if (grant_found) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = mem_tag_q[grant][rd_ptr_q[grant]];
                cdb_data_d  = mem_data_q[grant][rd_ptr_q[grant]];
                cdb_src_d   = grant;
                rr_ptr_d    = src_inc(grant, 1);
            end else begin
                cdb_valid_d = 1'b0;
                cdb_tag_d   = TAG_INVALID;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= TAG_INVALID;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    // Entry contents need no reset; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                mem_tag_q[i][wr_ptr_q[i]]  <= bus.src_tag[i*TAG_W +: TAG_W];
                mem_data_q[i][wr_ptr_q[i]] <= bus.src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.src_ready = src_ready;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_src   = cdb_src_q;
endmodule
